// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a dual-port RAM: one read and one write granted per cycle, round-robin per port.
// Optional RAM_ARB_BYPASS_EN forwards same-cycle same-address write data to the read return.
module ram_port_arbiter #(
    parameter int unsigned AddressSize = 15,
    parameter int unsigned WordSize    = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Req0,
    input  logic                   WE0,
    input  logic [AddressSize:0]   Addr0,
    input  logic [WordSize-1:0]    WData0,
    output logic                   Gnt0,
    output logic                   RValid0,
    input  logic                   Req1,
    input  logic                   WE1,
    input  logic [AddressSize:0]   Addr1,
    input  logic [WordSize-1:0]    WData1,
    output logic                   Gnt1,
    output logic                   RValid1,
    output logic [WordSize-1:0]    RData,
    output logic                   WErr,
    output logic [AddressSize:0]   RamAddrIN,
    output logic [WordSize-1:0]    RamDataIN,
    output logic                   RamWE,
    output logic [AddressSize-1:0] RamAddrOut,
    input  logic [WordSize-1:0]    RamDataOut
);

    localparam int unsigned AW = AddressSize + 1;
    localparam int unsigned RW = AddressSize;
    localparam int unsigned DW = WordSize;

    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;
    logic          werr_q, werr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [RW-1:0] ram_addr_out_q, ram_addr_out_d;

    logic          rd_req0, rd_req1, wr_req0, wr_req1;
    logic          rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;
    logic          rd_any, wr_any;
    logic [RW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rvalid0_c, rvalid1_c;
    logic [DW-1:0] rd_ret;

`ifdef RAM_ARB_BYPASS_EN
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
`endif

    // Arbitration, RAM drive and read-return selection
    always_comb begin
        rd_req0 = Req0 & ~WE0 & ~RST;
        rd_req1 = Req1 & ~WE1 & ~RST;
        wr_req0 = Req0 &  WE0 & ~RST;
        wr_req1 = Req1 &  WE1 & ~RST;

        rd_gnt0 = rd_req0 & (~rd_req1 | ~rd_ptr_q);
        rd_gnt1 = rd_req1 & (~rd_req0 |  rd_ptr_q);
        wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_ptr_q);
        wr_gnt1 = wr_req1 & (~wr_req0 |  wr_ptr_q);

        // Pointer moves to the loser only on contention
        rd_ptr_d = (rd_req0 & rd_req1) ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = (wr_req0 & wr_req1) ? ~wr_ptr_q : wr_ptr_q;

        rd_any  = rd_gnt0 | rd_gnt1;
        wr_any  = wr_gnt0 | wr_gnt1;
        rd_addr = rd_gnt1 ? Addr1[RW-1:0] : Addr0[RW-1:0];
        wr_addr = wr_gnt1 ? Addr1 : Addr0;
        wr_data = wr_gnt1 ? WData1 : WData0;

        ram_addr_out_d = rd_any ? rd_addr : ram_addr_out_q;
        rd_pend_d      = rd_any;
        rd_owner_d     = rd_gnt1;
        werr_d         = wr_any & ~wr_addr[AW-1];

        rvalid0_c = rd_pend_q & ~rd_owner_q & ~RST;
        rvalid1_c = rd_pend_q &  rd_owner_q & ~RST;

`ifdef RAM_ARB_BYPASS_EN
        byp_d      = rd_any & wr_any & wr_addr[AW-1] & (wr_addr[RW-1:0] == rd_addr);
        byp_data_d = wr_data;
        rd_ret     = byp_q ? byp_data_q : RamDataOut;
`else
        rd_ret     = RamDataOut;
`endif

        rdata_d = (rvalid0_c | rvalid1_c) ? rd_ret : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_owner_q     <= 1'b0;
            werr_q         <= 1'b0;
            rdata_q        <= '0;
            ram_addr_out_q <= '0;
`ifdef RAM_ARB_BYPASS_EN
            byp_q          <= 1'b0;
            byp_data_q     <= '0;
`endif
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_pend_q      <= rd_pend_d;
            rd_owner_q     <= rd_owner_d;
            werr_q         <= werr_d;
            rdata_q        <= rdata_d;
            ram_addr_out_q <= ram_addr_out_d;
`ifdef RAM_ARB_BYPASS_EN
            byp_q          <= byp_d;
            byp_data_q     <= byp_data_d;
`endif
        end
    end

    assign Gnt0       = rd_gnt0 | wr_gnt0;
    assign Gnt1       = rd_gnt1 | wr_gnt1;
    assign RValid0    = rvalid0_c;
    assign RValid1    = rvalid1_c;
    assign RData      = rdata_d;
    assign WErr       = werr_q & ~RST;
    assign RamAddrIN  = wr_addr;
    assign RamDataIN  = wr_data;
    assign RamWE      = wr_any & wr_addr[AW-1];
    assign RamAddrOut = ram_addr_out_d;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural read-before-write RAM model.
module tb_ram_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        Req0, WE0, Req1, WE1;
    logic [15:0] Addr0, Addr1;
    logic [7:0]  WData0, WData1;
    logic        Gnt0, Gnt1, RValid0, RValid1, WErr, RamWE;
    logic [7:0]  RData, RamDataIN, RamDataOut;
    logic [15:0] RamAddrIN;
    logic [14:0] RamAddrOut;

    logic [7:0]  mem [0:32767];
    logic        pre_we;
    logic [14:0] pre_a;
    logic [7:0]  pre_d;

    typedef struct {
        logic       owner;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks;
    int failures;

    ram_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .Req0(Req0), .WE0(WE0), .Addr0(Addr0), .WData0(WData0), .Gnt0(Gnt0), .RValid0(RValid0),
        .Req1(Req1), .WE1(WE1), .Addr1(Addr1), .WData1(WData1), .Gnt1(Gnt1), .RValid1(RValid1),
        .RData(RData), .WErr(WErr),
        .RamAddrIN(RamAddrIN), .RamDataIN(RamDataIN), .RamWE(RamWE),
        .RamAddrOut(RamAddrOut), .RamDataOut(RamDataOut)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM chip model: registered read, read-before-write
    always @(posedge CLK) begin
        RamDataOut <= mem[RamAddrOut];
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (RamWE)
            mem[RamAddrIN[14:0]] <= RamDataIN;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic owner, input logic [7:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [7:0] d1);
        @(posedge CLK);
        #1;
        Req0 = r0; WE0 = w0; Addr0 = a0; WData0 = d0;
        Req1 = r1; WE1 = w1; Addr1 = a1; WData1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    // Read-return monitor
    always @(negedge CLK) begin
        if (RValid0 || RValid1) begin
            exp_t e;
            if (RValid0 && RValid1) begin
                checks++;
                failures++;
                $display("FAIL rvalid_both actual=11 expected=one-hot");
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rvalid_unexpected actual=%0b%0b expected=none", RValid1, RValid0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_owner", 32'(RValid1), 32'(e.owner));
                chk("rdata", 32'(RData), 32'(e.data));
            end
        end
    end

    logic [14:0] pa [6];
    logic [7:0]  pd [6];

`ifdef RAM_ARB_BYPASS_EN
    localparam logic [7:0] SameAddrExp = 8'h22;
`else
    localparam logic [7:0] SameAddrExp = 8'h11;
`endif

    initial begin
        checks = 0; failures = 0;
        RST = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        Req0 = 1'b1; WE0 = 1'b0; Addr0 = 16'h8010; WData0 = 8'h0;
        Req1 = 1'b0; WE1 = 1'b0; Addr1 = 16'h0;    WData1 = 8'h0;
        pa[0] = 15'h0010; pd[0] = 8'h5A;
        pa[1] = 15'h0100; pd[1] = 8'hC1;
        pa[2] = 15'h0200; pd[2] = 8'hD2;
        pa[3] = 15'h0030; pd[3] = 8'h33;
        pa[4] = 15'h1234; pd[4] = 8'h4E;
        pa[5] = 15'h0040; pd[5] = 8'h11;

        // Preload RAM under reset while Req0 is held (must not be granted)
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            pre_we = 1'b1; pre_a = pa[i]; pre_d = pd[i];
            @(negedge CLK);
            chk("rst_gnt0", 32'(Gnt0), 32'd0);
            chk("rst_ramwe", 32'(RamWE), 32'd0);
        end
        @(posedge CLK);
        #1;
        pre_we = 1'b0; Req0 = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_rvalid0", 32'(RValid0), 32'd0);
        chk("rst_rvalid1", 32'(RValid1), 32'd0);
        chk("rst_rdata", 32'(RData), 32'd0);
        chk("rst_ramaddrout", 32'(RamAddrOut), 32'd0);
        chk("rst_werr", 32'(WErr), 32'd0);

        // Single read
        drive(1'b1, 1'b0, 16'h8010, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge CLK);
        chk("single_gnt0", 32'(Gnt0), 32'd1);
        chk("single_gnt1", 32'(Gnt1), 32'd0);
        chk("single_ramaddrout", 32'(RamAddrOut), 32'h0010);
        push(1'b0, 8'h5A);

        // Contended reads alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h8100, 8'h0, 1'b1, 1'b0, 16'h8200, 8'h0);
            @(negedge CLK);
            chk("rr_rd_gnt0", 32'(Gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_rd_gnt1", 32'(Gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) push(1'b0, 8'hC1);
            else            push(1'b1, 8'hD2);
        end

        // Concurrent write (req0) and read (req1)
        drive(1'b1, 1'b1, 16'h8020, 8'hA5, 1'b1, 1'b0, 16'h8030, 8'h0);
        @(negedge CLK);
        chk("rw_gnt0", 32'(Gnt0), 32'd1);
        chk("rw_gnt1", 32'(Gnt1), 32'd1);
        chk("rw_ramwe", 32'(RamWE), 32'd1);
        chk("rw_ramaddrin", 32'(RamAddrIN), 32'h8020);
        chk("rw_ramdatain", 32'(RamDataIN), 32'hA5);
        push(1'b1, 8'h33);

        // Out-of-window write
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h1234, 8'h77);
        @(negedge CLK);
        chk("oow_gnt1", 32'(Gnt1), 32'd1);
        chk("oow_ramwe", 32'(RamWE), 32'd0);
        chk("oow_werr_same", 32'(WErr), 32'd0);
        idle();
        @(negedge CLK);
        chk("oow_werr_pulse", 32'(WErr), 32'd1);
        idle();
        @(negedge CLK);
        chk("oow_werr_clear", 32'(WErr), 32'd0);

        // Contended writes alternate 0,1
        drive(1'b1, 1'b1, 16'h8050, 8'h01, 1'b1, 1'b1, 16'h8060, 8'h02);
        @(negedge CLK);
        chk("rr_wr0_gnt0", 32'(Gnt0), 32'd1);
        chk("rr_wr0_gnt1", 32'(Gnt1), 32'd0);
        chk("rr_wr0_addr", 32'(RamAddrIN), 32'h8050);
        drive(1'b1, 1'b1, 16'h8050, 8'h01, 1'b1, 1'b1, 16'h8060, 8'h02);
        @(negedge CLK);
        chk("rr_wr1_gnt0", 32'(Gnt0), 32'd0);
        chk("rr_wr1_gnt1", 32'(Gnt1), 32'd1);
        chk("rr_wr1_addr", 32'(RamAddrIN), 32'h8060);
        chk("rr_wr1_data", 32'(RamDataIN), 32'h02);

        // Same-address read and write in one cycle
        drive(1'b1, 1'b0, 16'h8040, 8'h0, 1'b1, 1'b1, 16'h8040, 8'h22);
        @(negedge CLK);
        chk("same_gnt0", 32'(Gnt0), 32'd1);
        chk("same_gnt1", 32'(Gnt1), 32'd1);
        chk("same_ramwe", 32'(RamWE), 32'd1);
        push(1'b0, SameAddrExp);

        // Read-backs: written data landed, out-of-window write did not
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h8020, 8'h0);
        @(negedge CLK); chk("rb_gnt1", 32'(Gnt1), 32'd1); push(1'b1, 8'hA5);
        drive(1'b1, 1'b0, 16'h9234, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge CLK); chk("rb_gnt0", 32'(Gnt0), 32'd1); push(1'b0, 8'h4E);
        drive(1'b1, 1'b0, 16'h8040, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge CLK); push(1'b0, 8'h22);
        drive(1'b1, 1'b0, 16'h8050, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge CLK); push(1'b0, 8'h01);
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h8060, 8'h0);
        @(negedge CLK); push(1'b1, 8'h02);

        // Move read pointer to requester 1, then reset in the middle of a read
        drive(1'b1, 1'b0, 16'h8100, 8'h0, 1'b1, 1'b0, 16'h8200, 8'h0);
        @(negedge CLK);
        chk("pre_rst_gnt0", 32'(Gnt0), 32'd1);
        push(1'b0, 8'hC1);
        drive(1'b1, 1'b0, 16'h8010, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge CLK);
        chk("midrst_gnt0", 32'(Gnt0), 32'd1);
        idle();
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_rvalid0", 32'(RValid0), 32'd0);
        chk("midrst_rvalid1", 32'(RValid1), 32'd0);
        idle();
        @(negedge CLK);
        drive(1'b1, 1'b0, 16'h8100, 8'h0, 1'b1, 1'b0, 16'h8200, 8'h0);
        RST = 1'b0;
        @(negedge CLK);
        chk("postrst_gnt0", 32'(Gnt0), 32'd1);
        chk("postrst_gnt1", 32'(Gnt1), 32'd0);
        push(1'b0, 8'hC1);
        drive(1'b1, 1'b0, 16'h8100, 8'h0, 1'b1, 1'b0, 16'h8200, 8'h0);
        @(negedge CLK);
        chk("postrst2_gnt1", 32'(Gnt1), 32'd1);
        push(1'b1, 8'hD2);
        idle();
        idle();
        idle();
        @(negedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single dual-port RAM chip (independent write port and registered read port) between two requesters, e.g. CPU core (requester 0) and DMA/video fetch (requester 1).
- Schedules one read and one write per cycle. A read from one requester and a write from the other are granted in the same cycle.
- Same-type conflicts are resolved by round-robin, with a separate pointer per port.
- Returns read data with the RAM's 1-cycle latency. Blocks writes that fall outside the RAM window (address bit AddressSize = 0, i.e. below 0x8000).

Parameters:
- AddressSize, 15, RAM word-address width. Requester addresses are AddressSize+1 bits wide.
- WordSize, 8, data width.

Ports:
- CLK  in  1  clock, all state on posedge
- RST  in  1  synchronous active-high reset
- Req0  in  1  requester 0 access request; held until Gnt0
- WE0  in  1  requester 0 access type: 1 = write, 0 = read
- Addr0  in  AddressSize+1  requester 0 full CPU address
- WData0  in  WordSize  requester 0 write data
- Gnt0  out  1  combinational grant; access is consumed this cycle
- RValid0  out  1  read data for requester 0 valid on RData this cycle
- Req1/WE1/Addr1/WData1/Gnt1/RValid1  same as above, requester 1
- RData  out  WordSize  shared read-return data
- WErr  out  1  one-cycle pulse: a write outside the RAM window was dropped
- RamAddrIN  out  AddressSize+1  to RAM write address (full address; RAM subtracts 0x8000)
- RamDataIN  out  WordSize  to RAM write data
- RamWE  out  1  to RAM write enable
- RamAddrOut  out  AddressSize  to RAM read address (= Addr[AddressSize-1:0])
- RamDataOut  in  WordSize  from RAM, registered read data

Behaviour:
- Classification per cycle:
  - rdReq_i = Req_i & ~WE_i
  - wrReq_i = Req_i & WE_i
- Read port grant:
  - One rdReq: grant it.
  - Both rdReq: grant the requester RdPtr points at; next cycle RdPtr points at the loser.
  - Uncontended grants leave RdPtr unchanged.
- Write port grant: same rule using WrPtr.
- Gnt_i = read grant_i | write grant_i. Both ports may be granted in one cycle, always to different requesters.
- RAM drive:
  - RamAddrOut = granted reader's Addr[AddressSize-1:0]; hold last value when no read is granted.
  - RamAddrIN and RamDataIN = granted writer's Addr and WData.
  - RamWE = write grant & Addr[AddressSize]. RamWE = 0 when no write is granted.
- Out-of-window write: granted (consumed), RamWE stays 0, WErr = 1 on the next cycle.
- Read return:
  - RdPend (1 bit) and RdOwner are registered at the read grant.
  - Next cycle: RValid_owner = 1 and RData = RamDataOut. Total latency is 1 cycle from grant.
  - RData holds its last value when no RValid is asserted.
- Back-to-back reads: new grant every cycle, RValid every cycle, fully pipelined.
- Same-cycle read and write to the same RAM address: the read returns the old data (RAM read-before-write), unless RAM_ARB_BYPASS_EN is defined.
- Reset:
  - RdPtr = 0, WrPtr = 0 (requester 0 wins first).
  - RdPend = 0, RValid0/1 = 0, WErr = 0, RData = 0, RamAddrOut = 0.
  - Gnt0/1 = 0 and RamWE = 0 while RST is high.
  - A read granted in the cycle before RST rises gets no RValid.
  - Requests presented during RST are not consumed.
- Req deasserted without a grant: legal. No state change.

Optional Feature:
- Macro: RAM_ARB_BYPASS_EN.
- Defined:
  - In a cycle where a read and an in-window write are both granted, and Addr_wr - 0x8000 equals the read address, register a bypass flag and WData.
  - Next cycle RData = the bypassed WData instead of RamDataOut. Read-after-write in the same cycle therefore returns new data.
- Undefined: no bypass logic; RData always comes from RamDataOut.

Test Plan:
- Reset then single read: Req0=1, WE0=0, Addr0=0x8010, with RAM[0x0010]=0x5A -> Gnt0=1 same cycle, RamAddrOut=0x0010, RValid0=1 and RData=0x5A next cycle.
- Contended reads: Req0 and Req1 both reading every cycle for 4 cycles -> grants go 0,1,0,1; RValid pattern is the same, delayed 1 cycle.
- Concurrent read/write: Req0 writes 0x8020←0xA5 while Req1 reads 0x8030 -> Gnt0=Gnt1=1 in the same cycle, RamWE=1, RValid1 next cycle.
- Out-of-window write: Req1 writes 0x1234 -> Gnt1=1, RamWE=0, WErr pulse next cycle, RAM unchanged.
- Same-address read+write, RAM[0x0040]=0x11, write 0x22: without RAM_ARB_BYPASS_EN -> RData=0x11; with it -> RData=0x22.
- Reset mid-read: grant a read, assert RST the next cycle -> RValid0 stays 0, pointers return to 0, and the first contended grant after reset goes to requester 0.
